// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters,
// with a single-entry tagged response register under valid/ready backpressure.
module alu_share_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = 1,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned CTRL_W  = 6
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
   input  logic [NUM_REQ*XLEN-1:0]   req_op_a,
   input  logic [NUM_REQ*XLEN-1:0]   req_op_b,
   output logic [CTRL_W-1:0]         alu_ctrl,
   output logic [XLEN-1:0]           alu_op_a,
   output logic [XLEN-1:0]           alu_op_b,
   input  logic [XLEN-1:0]           alu_result,
   input  logic                      alu_branch,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [XLEN-1:0]           rsp_result,
   output logic                      rsp_branch,
   input  logic                      rsp_ready
);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   sel;
   logic [ID_W-1:0]   next_ptr;
   logic              any_valid;
   logic              can_issue;
   logic              accept;
   logic [NUM_REQ-1:0] grant;

   logic [CTRL_W-1:0] ctrl_arr [NUM_REQ];
   logic [XLEN-1:0]   op_a_arr [NUM_REQ];
   logic [XLEN-1:0]   op_b_arr [NUM_REQ];

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         ctrl_arr[i] = req_ctrl[i*CTRL_W +: CTRL_W];
         op_a_arr[i] = req_op_a[i*XLEN +: XLEN];
         op_b_arr[i] = req_op_b[i*XLEN +: XLEN];
      end
   end

   // Scan from rr_ptr upward with wrap; first valid requester wins.
   always_comb begin : select_p
      int unsigned idx;
      logic [ID_W-1:0] cand;
      sel       = '0;
      any_valid = 1'b0;
      idx       = 0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx  = (32'(rr_ptr) + k) % NUM_REQ;
         cand = ID_W'(idx);
         if (!any_valid && req_valid[cand]) begin
            any_valid = 1'b1;
            sel       = cand;
         end
      end
   end

   always_comb begin
      grant     = any_valid ? (NUM_REQ'(1) << sel) : '0;
      can_issue = !rsp_valid || rsp_ready;
      accept    = any_valid && can_issue && !reset;
      req_ready = accept ? grant : '0;
      alu_ctrl  = any_valid ? ctrl_arr[sel] : '0;
      alu_op_a  = any_valid ? op_a_arr[sel] : '0;
      alu_op_b  = any_valid ? op_b_arr[sel] : '0;
      next_ptr  = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_branch <= 1'b0;
         rr_ptr     <= '0;
      end else if (accept) begin
         rsp_valid  <= 1'b1;
         rsp_id     <= sel;
         rsp_result <= alu_result;
         rsp_branch <= alu_branch;
         rr_ptr     <= next_ptr;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios then random traffic,
// all compared cycle by cycle against a behavioural arbiter/response model.
module tb_alu_share_arbiter;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned ID_W    = 1;
   localparam int unsigned XLEN    = 32;
   localparam int unsigned CTRL_W  = 6;

   logic                      clock = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*CTRL_W-1:0] req_ctrl;
   logic [NUM_REQ*XLEN-1:0]   req_op_a;
   logic [NUM_REQ*XLEN-1:0]   req_op_b;
   logic [CTRL_W-1:0]         alu_ctrl;
   logic [XLEN-1:0]           alu_op_a;
   logic [XLEN-1:0]           alu_op_b;
   logic [XLEN-1:0]           alu_result;
   logic                      alu_branch;
   logic                      rsp_valid;
   logic [ID_W-1:0]           rsp_id;
   logic [XLEN-1:0]           rsp_result;
   logic                      rsp_branch;
   logic                      rsp_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int unsigned      m_ptr;
   bit               m_valid;
   int unsigned      m_id;
   logic [XLEN-1:0]  m_result;
   bit               m_branch;

   always #5 clock = ~clock;

   alu_share_arbiter #(
      .NUM_REQ(NUM_REQ),
      .ID_W   (ID_W),
      .XLEN   (XLEN),
      .CTRL_W (CTRL_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ctrl  (req_ctrl),
      .req_op_a  (req_op_a),
      .req_op_b  (req_op_b),
      .alu_ctrl  (alu_ctrl),
      .alu_op_a  (alu_op_a),
      .alu_op_b  (alu_op_b),
      .alu_result(alu_result),
      .alu_branch(alu_branch),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_result(rsp_result),
      .rsp_branch(rsp_branch),
      .rsp_ready (rsp_ready)
   );

   // Simple ALU: [4:3] 00 add, 01 sub, 10 branch compare, 11 xor.
   function automatic logic [XLEN:0] alu_fn(input logic [CTRL_W-1:0] c,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
      logic            br;
      logic [XLEN-1:0] r;
      br = 1'b0;
      r  = '0;
      case (c[4:3])
         2'b00: r = a + b;
         2'b01: r = a - b;
         2'b10: begin
            case (c[2:0])
               3'b000:  br = (a == b);
               3'b001:  br = (a != b);
               3'b100:  br = ($signed(a) <  $signed(b));
               3'b101:  br = ($signed(a) >= $signed(b));
               3'b110:  br = (a <  b);
               3'b111:  br = (a >= b);
               default: br = 1'b0;
            endcase
            r = {{(XLEN-1){1'b0}}, br};
         end
         default: r = a ^ b;
      endcase
      return {br, r};
   endfunction

   assign {alu_branch, alu_result} = alu_fn(alu_ctrl, alu_op_a, alu_op_b);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic [CTRL_W-1:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
      req_ctrl[i*CTRL_W +: CTRL_W] = c;
      req_op_a[i*XLEN +: XLEN]     = a;
      req_op_b[i*XLEN +: XLEN]     = b;
   endtask

   // One clock cycle: check combinational and registered outputs before the edge,
   // then advance the model across the edge. Inputs are driven 1 time unit after.
   task automatic step();
      int              sel;
      bit              can;
      logic [NUM_REQ-1:0] exp_ready;
      logic [CTRL_W-1:0]  s_ctrl;
      logic [XLEN-1:0]    s_a, s_b;
      logic [XLEN:0]      res;
      @(negedge clock);
      sel = -1;
      for (int k = 0; k < int'(NUM_REQ); k++) begin
         int idx;
         idx = (int'(m_ptr) + k) % int'(NUM_REQ);
         if (sel < 0 && req_valid[idx]) sel = idx;
      end
      can       = !m_valid || rsp_ready;
      exp_ready = '0;
      if (sel >= 0 && can && !reset) exp_ready[sel] = 1'b1;
      s_ctrl = '0; s_a = '0; s_b = '0;
      if (sel >= 0) begin
         s_ctrl = req_ctrl[sel*CTRL_W +: CTRL_W];
         s_a    = req_op_a[sel*XLEN +: XLEN];
         s_b    = req_op_b[sel*XLEN +: XLEN];
      end
      check("req_ready",  64'(req_ready),  64'(exp_ready));
      check("alu_ctrl",   64'(alu_ctrl),   64'(s_ctrl));
      check("alu_op_a",   64'(alu_op_a),   64'(s_a));
      check("alu_op_b",   64'(alu_op_b),   64'(s_b));
      check("rsp_valid",  64'(rsp_valid),  64'(m_valid));
      check("rsp_id",     64'(rsp_id),     64'(m_id));
      check("rsp_result", 64'(rsp_result), 64'(m_result));
      check("rsp_branch", 64'(rsp_branch), 64'(m_branch));
      @(posedge clock);
      if (reset) begin
         m_valid = 0; m_id = 0; m_result = '0; m_branch = 0; m_ptr = 0;
      end else if (exp_ready != '0) begin
         res      = alu_fn(s_ctrl, s_a, s_b);
         m_valid  = 1;
         m_id     = int'(sel);
         m_result = res[XLEN-1:0];
         m_branch = res[XLEN];
         m_ptr    = (int'(sel) + 1) % NUM_REQ;
      end else if (m_valid && rsp_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   initial begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_result = '0; m_branch = 0;
      reset     = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      req_ctrl  = '0;
      req_op_a  = '0;
      req_op_b  = '0;
      set_req(0, 6'b000000, 32'd5, 32'd7);
      set_req(1, 6'b001000, 32'd9, 32'd3);
      #1;

      // Reset with both requesters pending, then first grant goes to requester 0
      step();
      reset = 1'b0;
      step();
      check("t1_valid", 64'(rsp_valid), 64'd1);
      check("t1_id",    64'(rsp_id),    64'd0);

      // Alternating grants: req1 SUB (6), req0 ADD (12), ...
      for (int i = 0; i < 6; i++) begin
         step();
         check("t2_result", 64'(rsp_result), (i % 2 == 0) ? 64'd6 : 64'd12);
      end

      // Stall with a pending request, then same-cycle drain and accept
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      rsp_ready = 1'b1;
      step();
      check("t3_valid", 64'(rsp_valid), 64'd1);

      // Signed vs unsigned branch compare on requester 1
      req_valid = 2'b10;
      set_req(1, 6'b010100, 32'hFFFF_FFFF, 32'd1);
      step();
      check("t4_blt_br",  64'(rsp_branch), 64'd1);
      check("t4_blt_res", 64'(rsp_result), 64'd1);
      check("t4_blt_id",  64'(rsp_id),     64'd1);
      set_req(1, 6'b010110, 32'hFFFF_FFFF, 32'd1);
      step();
      check("t4_bltu_br", 64'(rsp_branch), 64'd0);

      // Idle cycles must not rotate priority
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      for (int i = 0; i < 4; i++) step();
      check("t5_drained", 64'(rsp_valid), 64'd0);
      req_valid = 2'b11;
      step();
      check("t5_id", 64'(rsp_id), 64'd1);

      // Reset while a response is stalled
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_valid", 64'(rsp_valid), 64'd0);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      step();
      check("t6_id", 64'(rsp_id), 64'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         req_valid = NUM_REQ'($urandom);
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int r = 0; r < int'(NUM_REQ); r++) begin
            logic [CTRL_W-1:0] c;
            c = CTRL_W'($urandom);
            set_req(r, c, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
